bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer.sv | 143 ++++++++++++++
 tb/tb_bit_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a 2-entry input FIFO.
// Words are queued on LOAD_VALID & LOAD_READY and shifted out one bit per cycle on SOUT.
// Back-to-back words are emitted with no idle gap between them.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             SOUT,
  output logic             SVALID,
  output logic             FRAME_START,
  output logic             BUSY
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] fifo_q [2];
  logic [WIDTH-1:0] fifo_d [2];
  logic [1:0]       occ_q, occ_d;
  logic             ready_q, ready_d;
  logic             sout_q, sout_d;
  logic             svalid_q, svalid_d;
  logic             fstart_q, fstart_d;

  logic             push;
  logic             pop;
  logic             last_bit;
  logic [CntW-1:0]  bit_idx;

  // Transfer/pop handshakes; pop happens when the shifter is empty or finishing its last bit
  always_comb begin
    push     = LOAD_VALID & ready_q;
    last_bit = (cnt_q == LastIdx);
    pop      = (occ_q != 2'd0) && ((state_q == StIdle) || last_bit);
    bit_idx  = MSB_FIRST ? (LastIdx - cnt_q) : cnt_q;
  end

  // FIFO next state: entry 0 is always the head
  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    occ_d     = occ_q;
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) fifo_d[0] = LOAD_DATA;
        else               fifo_d[1] = LOAD_DATA;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        fifo_d[0] = fifo_q[1];
        occ_d     = occ_q - 2'd1;
      end
      // push implies occupancy < 2 and pop implies >= 1, so exactly one entry is being replaced
      2'b11: fifo_d[0] = LOAD_DATA;
      default: ;
    endcase
    ready_d = (occ_d < 2'd2);
  end

  // Shifter FSM next state and registered serial outputs
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    sout_d   = IDLE_BIT;
    svalid_d = 1'b0;
    fstart_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StShift;
          shreg_d = fifo_q[0];
          cnt_d   = '0;
        end
      end
      StShift: begin
        sout_d   = shreg_q[bit_idx];
        svalid_d = 1'b1;
        fstart_d = (cnt_q == '0);
        if (last_bit) begin
          if (pop) begin
            // Reload immediately so the next word follows without a gap
            shreg_d = fifo_q[0];
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shreg_q   <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      occ_q     <= 2'd0;
      ready_q   <= 1'b0;
      sout_q    <= IDLE_BIT;
      svalid_q  <= 1'b0;
      fstart_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      occ_q     <= occ_d;
      ready_q   <= ready_d;
      sout_q    <= sout_d;
      svalid_q  <= svalid_d;
      fstart_q  <= fstart_d;
    end
  end

  // Output mapping; BUSY follows the current state and occupancy directly
  always_comb begin
    LOAD_READY  = ready_q;
    SOUT        = sout_q;
    SVALID      = svalid_q;
    FRAME_START = fstart_q;
    BUSY        = (state_q == StShift) || (occ_q != 2'd0);
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first/idle-high instance and an
// LSB-first/idle-low instance share clock and reset.
module tb_bit_serializer;

  logic       clk;
  logic       reset;
  logic [7:0] d1, d2;
  logic       v1, v2;
  logic       r1, s1, sv1, fs1, b1;
  logic       r2, s2, sv2, fs2, b2;

  int n_cmp = 0;
  int n_fail = 0;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_msb (
    .CLK(clk), .RESET(reset), .LOAD_DATA(d1), .LOAD_VALID(v1), .LOAD_READY(r1),
    .SOUT(s1), .SVALID(sv1), .FRAME_START(fs1), .BUSY(b1)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .CLK(clk), .RESET(reset), .LOAD_DATA(d2), .LOAD_VALID(v2), .LOAD_READY(r2),
    .SOUT(s2), .SVALID(sv2), .FRAME_START(fs2), .BUSY(b2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and sample just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check one serial bit on the MSB-first instance
  task automatic chk_bit(input string tag, input logic b, input logic fs);
    chk({tag, "_sout"}, {31'd0, s1}, {31'd0, b});
    chk({tag, "_svalid"}, {31'd0, sv1}, 32'd1);
    chk({tag, "_fstart"}, {31'd0, fs1}, {31'd0, fs});
  endtask

  logic [7:0]  w8;
  logic [23:0] s24;
  logic [31:0] s32;
  logic [3:0]  win;
  int          hits;
  int          hit_i;

  initial begin
    reset = 1'b1;
    v1 = 1'b0; v2 = 1'b0; d1 = 8'h00; d2 = 8'h00;

    // Reset state
    step(); step();
    chk("rst_sout", {31'd0, s1}, 32'd1);
    chk("rst_svalid", {31'd0, sv1}, 32'd0);
    chk("rst_fstart", {31'd0, fs1}, 32'd0);
    chk("rst_busy", {31'd0, b1}, 32'd0);
    chk("rst_ready", {31'd0, r1}, 32'd0);
    chk("rst_sout_lsb", {31'd0, s2}, 32'd0);
    chk("rst_ready_lsb", {31'd0, r2}, 32'd0);
    reset = 1'b0;
    step();
    chk("rel_ready", {31'd0, r1}, 32'd1);
    chk("rel_ready_lsb", {31'd0, r2}, 32'd1);

    // Single word 8'h77, MSB first
    w8 = 8'h77;
    d1 = w8; v1 = 1'b1;
    step();
    v1 = 1'b0;
    chk("t1_busy", {31'd0, b1}, 32'd1);
    chk("t1_svalid_acc", {31'd0, sv1}, 32'd0);
    step();
    chk("t1_svalid_pop", {31'd0, sv1}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk_bit($sformatf("t1_b%0d", i), w8[7-i], i == 0);
    end
    step();
    chk("t1_end_svalid", {31'd0, sv1}, 32'd0);
    chk("t1_end_sout", {31'd0, s1}, 32'd1);
    chk("t1_end_fstart", {31'd0, fs1}, 32'd0);
    chk("t1_end_busy", {31'd0, b1}, 32'd0);

    // Back-to-back A5, 3C, FF with LOAD_VALID held
    s24 = 24'hA53CFF;
    d1 = 8'hA5; v1 = 1'b1;
    step();
    chk("t2_ready_e0", {31'd0, r1}, 32'd1);
    d1 = 8'h3C;
    step();
    chk("t2_ready_e1", {31'd0, r1}, 32'd1);
    d1 = 8'hFF;
    step();
    chk("t2_ready_e2", {31'd0, r1}, 32'd0);
    v1 = 1'b0; d1 = 8'h00;
    for (int i = 0; i < 24; i++) begin
      if (i > 0) step();
      chk_bit($sformatf("t2_b%0d", i), s24[23-i], (i % 8) == 0);
    end
    step();
    chk("t2_end_svalid", {31'd0, sv1}, 32'd0);

    // Full FIFO: 4th word waits for LOAD_READY
    s32 = 32'h11223344;
    d1 = 8'h11; v1 = 1'b1;
    step();
    d1 = 8'h22;
    step();
    d1 = 8'h33;
    step();
    chk("t3_ready_full", {31'd0, r1}, 32'd0);
    d1 = 8'h44;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) step();
      chk_bit($sformatf("t3_b%0d", i), s32[31-i], (i % 8) == 0);
      if (i == 6) chk("t3_ready_still0", {31'd0, r1}, 32'd0);
      if (i == 7) chk("t3_ready_back1", {31'd0, r1}, 32'd1);
      if (i == 8) begin
        chk("t3_ready_after4", {31'd0, r1}, 32'd0);
        v1 = 1'b0; d1 = 8'hC3;
      end
    end
    step();
    chk("t3_end_svalid", {31'd0, sv1}, 32'd0);

    // Reset at bit 3 of the first of three queued words
    w8 = 8'hA1;
    d1 = 8'hA1; v1 = 1'b1;
    step();
    d1 = 8'hB2;
    step();
    d1 = 8'hC3;
    step();
    v1 = 1'b0;
    chk_bit("t4_b0", w8[7], 1'b1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_bit($sformatf("t4_b%0d", i), w8[7-i], 1'b0);
    end
    reset = 1'b1; v1 = 1'b1; d1 = 8'hEE;
    step();
    chk("t4_rst_svalid", {31'd0, sv1}, 32'd0);
    chk("t4_rst_sout", {31'd0, s1}, 32'd1);
    chk("t4_rst_fstart", {31'd0, fs1}, 32'd0);
    chk("t4_rst_busy", {31'd0, b1}, 32'd0);
    chk("t4_rst_ready", {31'd0, r1}, 32'd0);
    reset = 1'b0;
    step();
    v1 = 1'b0;
    chk("t4_rel_ready", {31'd0, r1}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("t4_quiet_sv%0d", i), {31'd0, sv1}, 32'd0);
      chk($sformatf("t4_quiet_busy%0d", i), {31'd0, b1}, 32'd0);
    end
    w8 = 8'h0F;
    d1 = w8; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      chk_bit($sformatf("t4_new_b%0d", i), w8[7-i], i == 0);
    end
    step();
    chk("t4_new_end_svalid", {31'd0, sv1}, 32'd0);

    // LSB-first instance, 8'h01, idle level 0
    w8 = 8'h01;
    d2 = w8; v2 = 1'b1;
    step();
    v2 = 1'b0;
    step();
    chk("t5_pre_svalid", {31'd0, sv2}, 32'd0);
    chk("t5_pre_sout", {31'd0, s2}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("t5_b%0d_sout", i), {31'd0, s2}, {31'd0, w8[i]});
      chk($sformatf("t5_b%0d_svalid", i), {31'd0, sv2}, 32'd1);
      chk($sformatf("t5_b%0d_fstart", i), {31'd0, fs2}, (i == 0) ? 32'd1 : 32'd0);
    end
    step();
    chk("t5_end_svalid", {31'd0, sv2}, 32'd0);
    chk("t5_end_sout", {31'd0, s2}, 32'd0);

    // 0111 detector fed from SOUT with 8'h07: one hit on the final bit
    w8 = 8'h07;
    d1 = w8; v1 = 1'b1;
    step();
    v1 = 1'b0;
    step();
    win = 4'b0000; hits = 0; hit_i = -1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk_bit($sformatf("t6_b%0d", i), w8[7-i], i == 0);
      if (sv1) begin
        win = {win[2:0], s1};
        if (i >= 3 && win == 4'b0111) begin
          hits++;
          hit_i = i;
        end
      end
    end
    chk("t6_det_hits", hits, 32'd1);
    chk("t6_det_pos", hit_i, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
